adc_scan_sequencer: RTL



---
 rtl/adc_scan_sequencer_if.sv | 10 +
 rtl/adc_scan_sequencer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/adc_scan_sequencer_if.sv
// rtl/adc_scan_sequencer_if.sv - serial ADC pin bundle between sequencer and converter
interface adc_scan_sequencer_if;
    logic ADC_CONVST;
    logic ADC_SCK;
    logic ADC_SDI;
    logic ADC_SDO;

    modport master (output ADC_CONVST, output ADC_SCK, output ADC_SDI, input ADC_SDO);
    modport slave  (input ADC_CONVST, input ADC_SCK, input ADC_SDI, output ADC_SDO);
endinterface

// File: rtl/adc_scan_sequencer.sv
// rtl/adc_scan_sequencer.sv - round-robin LTC2308-style ADC scan sequencer
module adc_scan_sequencer #(
    parameter int NUM_CH        = 6,
    parameter int CONVST_CYCLES = 2,
    parameter int CONV_CYCLES   = 80,
    parameter int SCK_HALF      = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    adc_scan_sequencer_if.master adc,
    output logic [11:0]          ch0,
    output logic [11:0]          ch1,
    output logic [11:0]          ch2,
    output logic [11:0]          ch3,
    output logic [11:0]          ch4,
    output logic [11:0]          ch5,
    output logic [11:0]          ch6,
    output logic [11:0]          ch7,
    output logic                 sample_valid,
    output logic [2:0]           sample_ch
);
    typedef enum logic [2:0] {IDLE, CONVST, WAIT_CONV, SHIFT, STORE} state_t;

    localparam logic [15:0] CONVST_LAST = 16'(CONVST_CYCLES - 1);
    localparam logic [15:0] CONV_LAST   = 16'(CONV_CYCLES - 1);
    localparam logic [15:0] HALF_LAST   = 16'(SCK_HALF - 1);
    localparam logic [2:0]  CH_LAST     = 3'(NUM_CH - 1);

    state_t      state, state_nx;
    logic [15:0] cnt;
    logic [4:0]  half;
    logic        cnt_last;
    logic [2:0]  cfg_ch, res_ch;
    logic        primed;
    logic [11:0] shreg;
    logic [11:0] ch_reg [8];
    logic [5:0]  cfg_word, sdi_word;

    // Single-ended unipolar: {S/D, O/S, S1, S0, UNI, SLP}
    assign cfg_word = {1'b1, cfg_ch[0], cfg_ch[2], cfg_ch[1], 1'b1, 1'b0};
    // Each completed SCK pulse advances SDI one bit; past bit 0 the shift leaves zeros
    assign sdi_word = cfg_word << half[4:1];

    always_comb begin
        cnt_last = 1'b0;
        case (state)
            CONVST:    cnt_last = (cnt == CONVST_LAST);
            WAIT_CONV: cnt_last = (cnt == CONV_LAST);
            SHIFT:     cnt_last = (cnt == HALF_LAST);
            default:   cnt_last = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (enable) state_nx = CONVST;
            CONVST:    if (cnt_last) state_nx = WAIT_CONV;
            WAIT_CONV: if (cnt_last) state_nx = SHIFT;
            SHIFT:     if (cnt_last && half == 5'd23) state_nx = STORE;
            STORE:     state_nx = enable ? CONVST : IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        adc.ADC_CONVST = 1'b0;
        adc.ADC_SCK    = 1'b0;
        adc.ADC_SDI    = 1'b0;
        case (state)
            CONVST:    adc.ADC_CONVST = 1'b1;
            WAIT_CONV: adc.ADC_SDI = cfg_word[5];
            SHIFT: begin
                adc.ADC_SCK = half[0];
                adc.ADC_SDI = sdi_word[5];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            half         <= '0;
            cfg_ch       <= '0;
            res_ch       <= '0;
            primed       <= 1'b0;
            shreg        <= '0;
            sample_valid <= 1'b0;
            sample_ch    <= '0;
            for (int i = 0; i < 8; i++) ch_reg[i] <= '0;
        end else begin
            sample_valid <= 1'b0;
            if (cnt_last || state_nx != state) cnt <= '0;
            else if (state != IDLE)            cnt <= cnt + 16'd1;

            if (state != SHIFT) half <= '0;
            else if (cnt_last)  half <= half + 5'd1;

            // SDO is captured on the first clk of each SCK high phase
            if (state == SHIFT && half[0] && cnt == '0)
                shreg <= {shreg[10:0], adc.ADC_SDO};

            if (state == STORE) begin
                if (primed) begin
                    ch_reg[res_ch] <= shreg;
                    sample_valid   <= 1'b1;
                    sample_ch      <= res_ch;
                end
                res_ch <= cfg_ch;
                cfg_ch <= (cfg_ch == CH_LAST) ? 3'd0 : cfg_ch + 3'd1;
                // Returning to IDLE drops priming: the next frame's data is stale
                primed <= enable;
            end
        end
    end

    assign ch0 = (NUM_CH > 0) ? ch_reg[0] : 12'd0;
    assign ch1 = (NUM_CH > 1) ? ch_reg[1] : 12'd0;
    assign ch2 = (NUM_CH > 2) ? ch_reg[2] : 12'd0;
    assign ch3 = (NUM_CH > 3) ? ch_reg[3] : 12'd0;
    assign ch4 = (NUM_CH > 4) ? ch_reg[4] : 12'd0;
    assign ch5 = (NUM_CH > 5) ? ch_reg[5] : 12'd0;
    assign ch6 = (NUM_CH > 6) ? ch_reg[6] : 12'd0;
    assign ch7 = (NUM_CH > 7) ? ch_reg[7] : 12'd0;
endmodule
